// File: rtl/id_pkg.sv
// Shared constants for the RV32I decode/issue stage: ALU function codes,
// major opcodes and branch funct3 values.
package id_pkg;

    localparam int XLEN_MAX = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SGT  = 4'b1001;
    localparam logic [3:0] ALU_SGTU = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/id_imm_gen.sv
// Combinational RV32I immediate extraction: I, S, B, U and J formats,
// all sign-extended (U is left-aligned) to 32 bits.
module id_imm_gen
    import id_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm_i,
    output logic [31:0] imm_s,
    output logic [31:0] imm_b,
    output logic [31:0] imm_u,
    output logic [31:0] imm_j
);

    logic unused_opcode;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign unused_opcode = ^instr[6:0];

endmodule

// File: rtl/id_alu_issue.sv
// RV32I decode/issue stage feeding the execute ALU through a one-entry buffer.
// Optional macro ID_WB_BYPASS_EN forwards same-cycle writeback data into rs1/rs2.
module id_alu_issue
    import id_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            wb_wen,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [3:0]      ex_alu_fn,
    output logic [XLEN-1:0] ex_operand_a,
    output logic [XLEN-1:0] ex_operand_b,
    output logic            ex_btype,
    output logic            ex_bneq,
    output logic            ex_jump,
    output logic [XLEN-1:0] ex_target,
    output logic [4:0]      ex_rd,
    output logic            ex_wen,
    output logic [XLEN-1:0] ex_pc,
    output logic            ex_illegal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] rs1_val, rs2_val, jalr_sum;

    logic [3:0]      alu_fn_d;
    logic [XLEN-1:0] op_a_d, op_b_d, target_d;
    logic            btype_d, bneq_d, jump_d, wen_d, illegal_d;
    logic [4:0]      rd_d;
    logic            accept;

    logic            vld_p1;
    logic [3:0]      alu_fn_p1;
    logic [XLEN-1:0] op_a_p1, op_b_p1, target_p1, pc_p1;
    logic            btype_p1, bneq_p1, jump_p1, wen_p1, illegal_p1;
    logic [4:0]      rd_p1;

    assign opcode   = if_instr[6:0];
    assign funct3   = if_instr[14:12];
    assign funct7   = if_instr[31:25];
    assign rs1_addr = if_instr[19:15];
    assign rs2_addr = if_instr[24:20];

    id_imm_gen u_imm_gen (
        .instr (if_instr),
        .imm_i (imm_i),
        .imm_s (imm_s),
        .imm_b (imm_b),
        .imm_u (imm_u),
        .imm_j (imm_j)
    );

`ifdef ID_WB_BYPASS_EN
    // Regfile writes land at the edge, so a same-cycle read would see stale data.
    assign rs1_val = (wb_wen && wb_rd != 5'd0 && wb_rd == rs1_addr) ? wb_data : rs1_data;
    assign rs2_val = (wb_wen && wb_rd != 5'd0 && wb_rd == rs2_addr) ? wb_data : rs2_data;
`else
    logic unused_wb;
    assign unused_wb = ^{wb_wen, wb_rd, wb_data};
    assign rs1_val   = rs1_data;
    assign rs2_val   = rs2_data;
`endif

    assign jalr_sum = rs1_val + imm_i;

    // Stage 0: decode
    always_comb begin
        alu_fn_d  = ALU_ADD;
        op_a_d    = rs1_val;
        op_b_d    = rs2_val;
        target_d  = '0;
        btype_d   = 1'b0;
        bneq_d    = 1'b0;
        jump_d    = 1'b0;
        wen_d     = 1'b1;
        illegal_d = 1'b0;
        rd_d      = if_instr[11:7];
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE)
                    alu_fn_d = {1'b0, funct3};
                else if (funct7 == F7_ALT && funct3 == 3'b000)
                    alu_fn_d = ALU_SUB;
                else if (funct7 == F7_ALT && funct3 == 3'b101)
                    alu_fn_d = ALU_SRA;
                else
                    illegal_d = 1'b1;
            end
            OPC_OP_IMM: begin
                op_b_d = imm_i;
                case (funct3)
                    3'b000: alu_fn_d = ALU_ADD;
                    3'b001: begin
                        op_b_d    = {{(XLEN-5){1'b0}}, imm_i[4:0]};
                        alu_fn_d  = ALU_SLL;
                        illegal_d = (funct7 != F7_BASE);
                    end
                    3'b101: begin
                        op_b_d = {{(XLEN-5){1'b0}}, imm_i[4:0]};
                        if (funct7 == F7_BASE)
                            alu_fn_d = ALU_SRL;
                        else if (funct7 == F7_ALT)
                            alu_fn_d = ALU_SRA;
                        else
                            illegal_d = 1'b1;
                    end
                    default: alu_fn_d = {1'b0, funct3};
                endcase
            end
            OPC_BRANCH: begin
                btype_d  = 1'b1;
                wen_d    = 1'b0;
                rd_d     = 5'd0;
                target_d = if_pc + imm_b;
                case (funct3)
                    F3_BEQ:  alu_fn_d = ALU_SUB;
                    F3_BNE: begin
                        alu_fn_d = ALU_SUB;
                        bneq_d   = 1'b1;
                    end
                    F3_BLT:  alu_fn_d = ALU_SLT;
                    F3_BGE:  alu_fn_d = ALU_SGT;
                    F3_BLTU: alu_fn_d = ALU_SLTU;
                    F3_BGEU: alu_fn_d = ALU_SGTU;
                    default: illegal_d = 1'b1;
                endcase
            end
            OPC_LUI: begin
                op_a_d = '0;
                op_b_d = imm_u;
            end
            OPC_AUIPC: begin
                op_a_d = if_pc;
                op_b_d = imm_u;
            end
            OPC_LOAD: op_b_d = imm_i;
            OPC_STORE: begin
                op_b_d = imm_s;
                wen_d  = 1'b0;
                rd_d   = 5'd0;
            end
            OPC_JAL: begin
                jump_d   = 1'b1;
                op_a_d   = if_pc;
                op_b_d   = XLEN'(4);
                target_d = if_pc + imm_j;
            end
            OPC_JALR: begin
                jump_d   = 1'b1;
                op_a_d   = if_pc;
                op_b_d   = XLEN'(4);
                target_d = {jalr_sum[XLEN-1:1], 1'b0};
            end
            default: illegal_d = 1'b1;
        endcase
        if (rd_d == 5'd0)
            wen_d = 1'b0;
        // Illegal entries still issue, but must not branch, jump or write back.
        if (illegal_d) begin
            alu_fn_d = ALU_ADD;
            wen_d    = 1'b0;
            btype_d  = 1'b0;
            bneq_d   = 1'b0;
            jump_d   = 1'b0;
        end
    end

    assign if_ready = ~vld_p1 | ex_ready;
    assign accept   = if_valid & if_ready & ~flush;

    // Stage 1: issue buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            alu_fn_p1  <= '0;
            op_a_p1    <= '0;
            op_b_p1    <= '0;
            target_p1  <= '0;
            btype_p1   <= 1'b0;
            bneq_p1    <= 1'b0;
            jump_p1    <= 1'b0;
            wen_p1     <= 1'b0;
            illegal_p1 <= 1'b0;
            rd_p1      <= '0;
            pc_p1      <= RESET_PC;
        end else begin
            if (flush)
                vld_p1 <= 1'b0;
            else if (accept)
                vld_p1 <= 1'b1;
            else if (ex_ready)
                vld_p1 <= 1'b0;
            if (accept) begin
                alu_fn_p1  <= alu_fn_d;
                op_a_p1    <= op_a_d;
                op_b_p1    <= op_b_d;
                target_p1  <= target_d;
                btype_p1   <= btype_d;
                bneq_p1    <= bneq_d;
                jump_p1    <= jump_d;
                wen_p1     <= wen_d;
                illegal_p1 <= illegal_d;
                rd_p1      <= rd_d;
                pc_p1      <= if_pc;
            end
        end
    end

    assign ex_valid     = vld_p1;
    assign ex_alu_fn    = alu_fn_p1;
    assign ex_operand_a = op_a_p1;
    assign ex_operand_b = op_b_p1;
    assign ex_target    = target_p1;
    assign ex_btype     = btype_p1;
    assign ex_bneq      = bneq_p1;
    assign ex_jump      = jump_p1;
    assign ex_wen       = wen_p1;
    assign ex_illegal   = illegal_p1;
    assign ex_rd        = rd_p1;
    assign ex_pc        = pc_p1;

endmodule

// File: tb/tb_id_alu_issue.sv
// Self-checking bench for id_alu_issue: directed cases, then random traffic
// built from a mnemonic table and checked against a one-entry buffer model.
module tb_id_alu_issue;

    logic        clk, rst, flush, if_valid, if_ready, ex_ready, ex_valid;
    logic [31:0] if_instr, if_pc, rs1_data, rs2_data, wb_data;
    logic [4:0]  rs1_addr, rs2_addr, wb_rd, ex_rd;
    logic        wb_wen;
    logic [3:0]  ex_alu_fn;
    logic [31:0] ex_operand_a, ex_operand_b, ex_target, ex_pc;
    logic        ex_btype, ex_bneq, ex_jump, ex_wen, ex_illegal;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic        bt;
        logic        bn;
        logic        jp;
        logic [31:0] tg;
        logic [4:0]  rd;
        logic        cr;
        logic        wen;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    localparam int K_R = 0, K_I = 1, K_SH = 2, K_BR = 3, K_LUI = 4, K_AUI = 5;
    localparam int K_LD = 6, K_ST = 7, K_JAL = 8, K_JALR = 9, K_ILL = 10;

    id_alu_issue #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_fn(ex_alu_fn),
        .ex_operand_a(ex_operand_a), .ex_operand_b(ex_operand_b),
        .ex_btype(ex_btype), .ex_bneq(ex_bneq), .ex_jump(ex_jump), .ex_target(ex_target),
        .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_pc(ex_pc), .ex_illegal(ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_entry(input string tag, input exp_t e);
        chk({tag, "/fn"}, 32'(ex_alu_fn), 32'(e.fn));
        chk({tag, "/btype"}, 32'(ex_btype), 32'(e.bt));
        chk({tag, "/bneq"}, 32'(ex_bneq), 32'(e.bn));
        chk({tag, "/jump"}, 32'(ex_jump), 32'(e.jp));
        chk({tag, "/wen"}, 32'(ex_wen), 32'(e.wen));
        chk({tag, "/pc"}, ex_pc, e.pc);
        chk({tag, "/illegal"}, 32'(ex_illegal), 32'(e.ill));
        if (!e.ill) begin
            chk({tag, "/a"}, ex_operand_a, e.a);
            chk({tag, "/b"}, ex_operand_b, e.b);
            if (e.bt || e.jp) chk({tag, "/target"}, ex_target, e.tg);
            if (e.cr) chk({tag, "/rd"}, 32'(ex_rd), 32'(e.rd));
        end
    endtask

    function automatic logic [31:0] eff(input logic [4:0] idx, input logic [31:0] d);
        logic byp_on;
`ifdef ID_WB_BYPASS_EN
        byp_on = 1'b1;
`else
        byp_on = 1'b0;
`endif
        return (byp_on && wb_wen && wb_rd != 5'd0 && wb_rd == idx) ? wb_data : d;
    endfunction

    // Builds an encoding for mnemonic m and the outcome the ISA defines for it.
    task automatic gen(input int m, input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rdi, input logic [31:0] v1, input logic [31:0] v2,
                       output logic [31:0] ins, output exp_t e);
        int k, imm, off;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] fn;
        logic [31:0] iv, ov, u;
        logic [4:0] sh;
        k = K_R; f3 = 3'd0; f7 = 7'h00; fn = 4'd0;
        case (m)
            0:  begin k = K_R;  f3 = 3'd0; fn = 4'd0;  end
            1:  begin k = K_R;  f3 = 3'd0; f7 = 7'h20; fn = 4'd8; end
            2:  begin k = K_R;  f3 = 3'd1; fn = 4'd1;  end
            3:  begin k = K_R;  f3 = 3'd2; fn = 4'd2;  end
            4:  begin k = K_R;  f3 = 3'd3; fn = 4'd3;  end
            5:  begin k = K_R;  f3 = 3'd4; fn = 4'd4;  end
            6:  begin k = K_R;  f3 = 3'd5; fn = 4'd5;  end
            7:  begin k = K_R;  f3 = 3'd5; f7 = 7'h20; fn = 4'd13; end
            8:  begin k = K_R;  f3 = 3'd6; fn = 4'd6;  end
            9:  begin k = K_R;  f3 = 3'd7; fn = 4'd7;  end
            10: begin k = K_I;  f3 = 3'd0; fn = 4'd0;  end
            11: begin k = K_I;  f3 = 3'd2; fn = 4'd2;  end
            12: begin k = K_I;  f3 = 3'd3; fn = 4'd3;  end
            13: begin k = K_I;  f3 = 3'd4; fn = 4'd4;  end
            14: begin k = K_I;  f3 = 3'd6; fn = 4'd6;  end
            15: begin k = K_I;  f3 = 3'd7; fn = 4'd7;  end
            16: begin k = K_SH; f3 = 3'd1; fn = 4'd1;  end
            17: begin k = K_SH; f3 = 3'd5; fn = 4'd5;  end
            18: begin k = K_SH; f3 = 3'd5; f7 = 7'h20; fn = 4'd13; end
            19: begin k = K_BR; f3 = 3'd0; fn = 4'd8;  end
            20: begin k = K_BR; f3 = 3'd1; fn = 4'd8;  end
            21: begin k = K_BR; f3 = 3'd4; fn = 4'd2;  end
            22: begin k = K_BR; f3 = 3'd5; fn = 4'd9;  end
            23: begin k = K_BR; f3 = 3'd6; fn = 4'd3;  end
            24: begin k = K_BR; f3 = 3'd7; fn = 4'd10; end
            25: k = K_LUI;
            26: k = K_AUI;
            27: k = K_LD;
            28: k = K_ST;
            29: k = K_JAL;
            30: k = K_JALR;
            default: k = K_ILL;
        endcase
        e = '0;
        e.pc = pc; e.a = v1; e.b = v2; e.rd = rdi; e.cr = 1'b1; e.wen = (rdi != 5'd0); e.fn = fn;
        imm = int'($urandom_range(0, 4095)) - 2048;
        iv  = imm;
        u   = $urandom;
        sh  = 5'($urandom_range(0, 31));
        case (k)
            K_R:   ins = {f7, r2, r1, f3, rdi, 7'h33};
            K_I:   begin ins = {iv[11:0], r1, f3, rdi, 7'h13}; e.b = iv; end
            K_SH:  begin ins = {f7, sh, r1, f3, rdi, 7'h13}; e.b = 32'(sh); end
            K_BR: begin
                off = imm * 2;
                ov  = off;
                ins = {ov[12], ov[10:5], r2, r1, f3, ov[4:1], ov[11], 7'h63};
                e.bt = 1'b1; e.bn = (m == 20); e.wen = 1'b0; e.cr = 1'b0; e.tg = pc + ov;
            end
            K_LUI: begin ins = {u[31:12], rdi, 7'h37}; e.a = 32'd0; e.b = {u[31:12], 12'h000}; end
            K_AUI: begin ins = {u[31:12], rdi, 7'h17}; e.a = pc;    e.b = {u[31:12], 12'h000}; end
            K_LD:  begin ins = {iv[11:0], r1, 3'd2, rdi, 7'h03}; e.b = iv; end
            K_ST: begin
                ins = {iv[11:5], r2, r1, 3'd2, iv[4:0], 7'h23};
                e.b = iv; e.wen = 1'b0; e.cr = 1'b0;
            end
            K_JAL: begin
                off = (int'($urandom_range(0, 1048575)) - 524288) * 2;
                ov  = off;
                ins = {ov[20], ov[10:1], ov[11], ov[19:12], rdi, 7'h6f};
                e.a = pc; e.b = 32'd4; e.jp = 1'b1; e.tg = pc + ov;
            end
            K_JALR: begin
                ins = {iv[11:0], r1, 3'd0, rdi, 7'h67};
                e.a = pc; e.b = 32'd4; e.jp = 1'b1; e.tg = (v1 + iv) & 32'hFFFF_FFFE;
            end
            default: begin
                case (m)
                    31:      ins = {u[31:7], 7'h7f};
                    32:      ins = {7'h01, r2, r1, 3'd0, rdi, 7'h33};
                    33:      ins = {7'h00, r2, r1, 3'd2, 5'd8, 7'h63};
                    default: ins = {7'h20, sh, r1, 3'd1, rdi, 7'h13};
                endcase
                e.fn = 4'd0; e.ill = 1'b1; e.wen = 1'b0; e.cr = 1'b0;
            end
        endcase
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] d1, input logic [31:0] d2);
        if_instr = ins; if_pc = pc; rs1_data = d1; rs2_data = d2;
        if_valid = 1'b1; ex_ready = 1'b1;
        @(posedge clk); #1;
        if_valid = 1'b0;
    endtask

    initial begin
        exp_t e, mexp;
        logic mvalid, fl, iv_, er;
        logic [31:0] ins, pcv, d1, d2;
        logic [4:0] r1i, r2i, rdi;
        logic [31:0] hold_a;

        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b0;
        if_instr = 32'h0; if_pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;
        wb_wen = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
        #1;
        chk("reset/valid", 32'(ex_valid), 32'd0);
        chk("reset/pc", ex_pc, 32'h0);
        chk("reset/fn", 32'(ex_alu_fn), 32'd0);
        chk("reset/wen", 32'(ex_wen), 32'd0);
        chk("reset/if_ready", 32'(if_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // SUB x1, x1, x2
        if_instr = 32'h402080B3; #1;
        chk("sub/rs1_addr", 32'(rs1_addr), 32'd1);
        chk("sub/rs2_addr", 32'(rs2_addr), 32'd2);
        issue(32'h402080B3, 32'h40, 32'd5, 32'd3);
        chk("sub/valid", 32'(ex_valid), 32'd1);
        chk("sub/fn", 32'(ex_alu_fn), 32'h8);
        chk("sub/a", ex_operand_a, 32'd5);
        chk("sub/b", ex_operand_b, 32'd3);
        chk("sub/rd", 32'(ex_rd), 32'd1);
        chk("sub/wen", 32'(ex_wen), 32'd1);

        issue(32'h00209463, 32'h100, 32'd7, 32'd9);
        chk("bne/btype", 32'(ex_btype), 32'd1);
        chk("bne/bneq", 32'(ex_bneq), 32'd1);
        chk("bne/fn", 32'(ex_alu_fn), 32'h8);
        chk("bne/target", ex_target, 32'h108);
        chk("bne/wen", 32'(ex_wen), 32'd0);
        issue(32'h0020D463, 32'h100, 32'd7, 32'd9);
        chk("bge/fn", 32'(ex_alu_fn), 32'h9);
        chk("bge/bneq", 32'(ex_bneq), 32'd0);

        // Stall: SUB held while a BNE waits at the input
        issue(32'h402080B3, 32'h200, 32'd11, 32'd4);
        hold_a = ex_operand_a;
        if_instr = 32'h00209463; if_pc = 32'h300; if_valid = 1'b1; ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall/if_ready", 32'(if_ready), 32'd0);
            @(posedge clk); #1;
            chk("stall/valid", 32'(ex_valid), 32'd1);
            chk("stall/fn", 32'(ex_alu_fn), 32'h8);
            chk("stall/a", ex_operand_a, hold_a);
            chk("stall/pc", ex_pc, 32'h200);
        end
        ex_ready = 1'b1; #1;
        chk("release/if_ready", 32'(if_ready), 32'd1);
        @(posedge clk); #1;
        if_valid = 1'b0;
        chk("release/valid", 32'(ex_valid), 32'd1);
        chk("release/pc", ex_pc, 32'h300);
        chk("release/btype", 32'(ex_btype), 32'd1);
        @(posedge clk); #1;
        chk("release/drain", 32'(ex_valid), 32'd0);

        // Flush with a beat arriving and an entry held
        issue(32'h402080B3, 32'h400, 32'd1, 32'd1);
        if_instr = 32'h00108113; if_pc = 32'h404; if_valid = 1'b1; ex_ready = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; if_valid = 1'b0;
        chk("flush/valid", 32'(ex_valid), 32'd0);
        @(posedge clk); #1;
        chk("flush/dropped", 32'(ex_valid), 32'd0);

        issue(32'hFFFFFFFF, 32'h500, 32'd0, 32'd0);
        chk("illegal/valid", 32'(ex_valid), 32'd1);
        chk("illegal/flag", 32'(ex_illegal), 32'd1);
        chk("illegal/wen", 32'(ex_wen), 32'd0);
        chk("illegal/fn", 32'(ex_alu_fn), 32'd0);

        // addi x2, x1, 1 with x1 being written back this cycle
        wb_wen = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEAD;
        issue(32'h00108113, 32'h600, 32'h1234, 32'h0);
`ifdef ID_WB_BYPASS_EN
        chk("bypass/a", ex_operand_a, 32'hDEAD);
`else
        chk("bypass/a", ex_operand_a, 32'h1234);
`endif
        chk("bypass/b", ex_operand_b, 32'd1);
        wb_wen = 1'b0;

        // Reset mid-stream acts without waiting for an edge
        issue(32'h402080B3, 32'h700, 32'd5, 32'd3);
        chk("rstmid/pre", 32'(ex_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid/valid", 32'(ex_valid), 32'd0);
        chk("rstmid/pc", ex_pc, 32'h0);
        chk("rstmid/fn", 32'(ex_alu_fn), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        mvalid = 1'b0;
        mexp = '0;
        for (int c = 0; c < 800; c++) begin
            chk("rnd/valid", 32'(ex_valid), 32'(mvalid));
            if (mvalid) chk_entry("rnd", mexp);
            iv_ = ($urandom_range(0, 3) != 0);
            er  = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 15) == 0);
            r1i = 5'($urandom_range(0, 31));
            r2i = 5'($urandom_range(0, 31));
            rdi = 5'($urandom_range(0, 31));
            d1 = $urandom; d2 = $urandom;
            wb_wen  = 1'($urandom_range(0, 1));
            wb_rd   = ($urandom_range(0, 1) != 0) ? r1i : 5'($urandom_range(0, 31));
            wb_data = $urandom;
            pcv = $urandom; pcv[1:0] = 2'b00;
            gen(int'($urandom_range(0, 34)), pcv, r1i, r2i, rdi, eff(r1i, d1), eff(r2i, d2), ins, e);
            if_instr = ins; if_pc = pcv; rs1_data = d1; rs2_data = d2;
            if_valid = iv_; ex_ready = er; flush = fl;
            #1;
            chk("rnd/if_ready", 32'(if_ready), 32'(!mvalid || er));
            chk("rnd/rs1_addr", 32'(rs1_addr), 32'(ins[19:15]));
            chk("rnd/rs2_addr", 32'(rs2_addr), 32'(ins[24:20]));
            if (fl) mvalid = 1'b0;
            else if (iv_ && (!mvalid || er)) begin mvalid = 1'b1; mexp = e; end
            else if (er) mvalid = 1'b0;
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
